coffee_dispense_sequencer: RTL and testbench
============================================

Name: coffee_dispense_sequencer

Overview:
Consumes the drink-select result from the vending machine FSM and drives the physical dispense outputs: water, coffee, cream and sugar valves. Each valve is held on for a programmed number of 100 Hz ticks, in a fixed order.
The block sits between Coffee_Vending_machine and the board outputs (valve drivers / LEDs) and runs on the same divided 100 Hz clock.
It reports BUSY so the FSM can block new purchases, and pulses DONE when a cup is complete.

Parameters:
T_WATER, 300, water valve on-time in clock ticks (3 s at 100 Hz)
T_COFFEE, 200, coffee valve on-time in ticks
T_CREAM, 100, cream valve on-time in ticks
T_SUGAR, 100, sugar valve on-time in ticks
CNT_W, 10, width of the step timer; must satisfy 2^CNT_W > max(T_*)

Ports:
CLK  input  1  clock (clk_100 domain)
RST  input  1  reset, synchronous, active-high
START  input  1  single-cycle request pulse (edge-detected upstream)
RECIPE  input  2  01 black, 10 cream, 11 cream+sugar, 00 invalid; sampled only with START
ABORT  input  1  level or pulse; terminates any dispense
BUSY  output  1  high from the first valve cycle through the FINISH cycle
DONE  output  1  one-cycle pulse on normal completion
ABORTED  output  1  one-cycle pulse when ABORT ends an active dispense
VALVE_WATER  output  1  water valve enable
VALVE_COFFEE  output  1  coffee valve enable
VALVE_CREAM  output  1  cream valve enable
VALVE_SUGAR  output  1  sugar valve enable
STEP  output  3  current state code, for 7-seg display: 0 IDLE, 1 WATER, 2 COFFEE, 3 CREAM, 4 SUGAR, 5 FINISH

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset: all outputs are 0, state is IDLE, timer is 0, latched recipe is 00.
  - RST asserted mid-dispense closes all valves on the next edge.
  - A reset never produces DONE or ABORTED.
- All outputs are registered and decoded from state only. There are no combinational paths from inputs to outputs.
- States: IDLE, WATER, COFFEE, CREAM, SUGAR, FINISH.
- IDLE:
  - START=1, RECIPE!=00 and ABORT=0: latch RECIPE, load the timer with T_WATER-1, go to WATER.
  - START with RECIPE=00 is ignored.
- Step states:
  - Each step state lasts exactly T_x cycles. The timer counts down to 0, then the next state's T-1 is loaded.
  - Any T_x parameter of 0 is treated as 1.
- Sequence:
  - WATER goes to COFFEE.
  - COFFEE goes to CREAM if recipe[1]=1, else to FINISH.
  - CREAM goes to SUGAR if recipe=11, else to FINISH.
  - SUGAR goes to FINISH.
- FINISH lasts one cycle: DONE=1, BUSY=1, all valves 0. The next state is IDLE.
- Valves:
  - Exactly one valve is high in each step state: VALVE_WATER in WATER, VALVE_COFFEE in COFFEE, and so on.
  - Valves are never overlapped and never gapped between consecutive steps.
- Latency: START sampled at edge n gives VALVE_WATER=1 and BUSY=1 from cycle n+1.
- Cycle counts, with Tw, Tc, Tm, Ts standing for T_WATER, T_COFFEE, T_CREAM, T_SUGAR:
  - Black: DONE at cycle n+Tw+Tc+1; BUSY low at n+Tw+Tc+2.
  - Cream adds Tm cycles.
  - Cream+sugar adds Tm+Ts cycles.
- START while BUSY is ignored. The latched recipe cannot change mid-dispense.
- ABORT in any step state or FINISH:
  - Next state is IDLE and all valves are 0 on the next cycle.
  - ABORTED=1 for one cycle; DONE is not asserted.
  - ABORT in FINISH suppresses nothing: DONE was already issued that cycle, so ABORTED is not pulsed.
- ABORT in IDLE has no effect and produces no pulse. ABORT together with START in IDLE: ABORT wins and START is dropped.
- START arriving in the FINISH cycle is ignored. A new START is accepted only once the state is IDLE.
- The timer never wraps: a reload happens only at 0, and the width is checked by a parameter assertion.

Decomposition:
- Shared package vending_pkg holds:
  - the state enum and STEP codes
  - recipe codes RCP_NONE=00, RCP_BLACK=01, RCP_CREAM=10, RCP_CREAM_SUGAR=11
  - the tick-rate constant TICK_HZ=100
- One sub-module is natural: step_timer (loadable down-counter of width CNT_W, with load value, load strobe and zero flag).
- The FSM and output decode stay in coffee_dispense_sequencer.

Test Plan:
All scenarios use T_WATER=3, T_COFFEE=2, T_CREAM=2, T_SUGAR=1.
- Black: START with RECIPE=01 at cycle 0 -> VALVE_WATER high cycles 1-3, VALVE_COFFEE high 4-5, DONE at 6, BUSY high 1-6 and low at 7.
- Cream+sugar: START with RECIPE=11 -> water 1-3, coffee 4-5, cream 6-7, sugar 8, DONE at 9; STEP reads 1,1,1,2,2,3,3,4,5,0.
- Invalid and busy: START with RECIPE=00 -> no state change. START with 01 at cycle 2 during a cream dispense -> ignored; the cream cycle count is unchanged.
- Abort: START with 10, then ABORT at cycle 5 (COFFEE) -> cycle 6 has all valves 0, BUSY 0, ABORTED=1, no DONE. START on the same edge as ABORT in IDLE -> stays IDLE.
- Reset: RST at cycle 4 of a cream dispense -> cycle 5 has all outputs 0, no DONE or ABORTED; a fresh START with 01 then runs the full 6-cycle sequence.
- Back-to-back: START in the FINISH cycle is ignored. START in the following IDLE cycle is accepted, with water on the next cycle.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine datapath: FSM state codes,
// recipe encodings and the tick rate of the divided clock.
package vending_pkg;

  localparam int unsigned TICK_HZ = 32'd100;

  localparam logic [2:0] STEP_IDLE   = 3'd0;
  localparam logic [2:0] STEP_WATER  = 3'd1;
  localparam logic [2:0] STEP_COFFEE = 3'd2;
  localparam logic [2:0] STEP_CREAM  = 3'd3;
  localparam logic [2:0] STEP_SUGAR  = 3'd4;
  localparam logic [2:0] STEP_FINISH = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = STEP_IDLE,
    ST_WATER  = STEP_WATER,
    ST_COFFEE = STEP_COFFEE,
    ST_CREAM  = STEP_CREAM,
    ST_SUGAR  = STEP_SUGAR,
    ST_FINISH = STEP_FINISH
  } state_t;

  localparam logic [1:0] RCP_NONE        = 2'b00;
  localparam logic [1:0] RCP_BLACK       = 2'b01;
  localparam logic [1:0] RCP_CREAM       = 2'b10;
  localparam logic [1:0] RCP_CREAM_SUGAR = 2'b11;

  // A zero on-time would make a step vanish; every step lasts at least one tick.
  function automatic int unsigned eff_ticks(input int unsigned t);
    return (t == 32'd0) ? 32'd1 : t;
  endfunction

endpackage

// File: rtl/coffee_dispense_sequencer_step_timer.sv
// Loadable down-counter that times each dispense step; it parks at zero
// rather than wrapping, so a step can only advance on an explicit reload.
module step_timer #(
  parameter int CNT_W = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load has priority, otherwise decrement until zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/coffee_dispense_sequencer.sv
// Dispense sequencer: walks water -> coffee -> [cream -> [sugar]] -> finish,
// holding exactly one valve open per step for a programmed number of ticks.
module coffee_dispense_sequencer
  import vending_pkg::*;
#(
  parameter int unsigned T_WATER  = 32'd300,
  parameter int unsigned T_COFFEE = 32'd200,
  parameter int unsigned T_CREAM  = 32'd100,
  parameter int unsigned T_SUGAR  = 32'd100,
  parameter int          CNT_W    = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [1:0] RECIPE,
  input  logic       ABORT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ABORTED,
  output logic       VALVE_WATER,
  output logic       VALVE_COFFEE,
  output logic       VALVE_CREAM,
  output logic       VALVE_SUGAR,
  output logic [2:0] STEP
);

  localparam int unsigned TW_E = eff_ticks(T_WATER);
  localparam int unsigned TC_E = eff_ticks(T_COFFEE);
  localparam int unsigned TM_E = eff_ticks(T_CREAM);
  localparam int unsigned TS_E = eff_ticks(T_SUGAR);
  localparam int unsigned MAX_WC = (TW_E > TC_E) ? TW_E : TC_E;
  localparam int unsigned MAX_MS = (TM_E > TS_E) ? TM_E : TS_E;
  localparam int unsigned MAX_T  = (MAX_WC > MAX_MS) ? MAX_WC : MAX_MS;

  localparam logic [CNT_W-1:0] LD_WATER  = CNT_W'(TW_E - 32'd1);
  localparam logic [CNT_W-1:0] LD_COFFEE = CNT_W'(TC_E - 32'd1);
  localparam logic [CNT_W-1:0] LD_CREAM  = CNT_W'(TM_E - 32'd1);
  localparam logic [CNT_W-1:0] LD_SUGAR  = CNT_W'(TS_E - 32'd1);

  if ((64'd1 << CNT_W) <= 64'(MAX_T)) begin : g_cnt_w_too_small
    $error("coffee_dispense_sequencer: CNT_W too narrow for the longest step");
  end

  state_t           state_r;
  state_t           nxt_s;
  logic [1:0]       rcp_r;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             abort_hit_s;
  logic             tmr_zero_s;

  step_timer #(.CNT_W(CNT_W)) u_step_timer (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (tmr_zero_s)
  );

  // Next-state, timer reload and abort detection.
  always_comb begin
    nxt_s       = state_r;
    load_s      = 1'b0;
    load_val_s  = {CNT_W{1'b0}};
    abort_hit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (START && (RECIPE != RCP_NONE) && !ABORT) begin
          nxt_s      = ST_WATER;
          load_s     = 1'b1;
          load_val_s = LD_WATER;
        end else begin
          nxt_s = ST_IDLE;
        end
      end
      ST_WATER: begin
        if (tmr_zero_s) begin
          nxt_s      = ST_COFFEE;
          load_s     = 1'b1;
          load_val_s = LD_COFFEE;
        end else begin
          nxt_s = ST_WATER;
        end
      end
      ST_COFFEE: begin
        if (tmr_zero_s && rcp_r[1]) begin
          nxt_s      = ST_CREAM;
          load_s     = 1'b1;
          load_val_s = LD_CREAM;
        end else if (tmr_zero_s) begin
          nxt_s = ST_FINISH;
        end else begin
          nxt_s = ST_COFFEE;
        end
      end
      ST_CREAM: begin
        if (tmr_zero_s && (rcp_r == RCP_CREAM_SUGAR)) begin
          nxt_s      = ST_SUGAR;
          load_s     = 1'b1;
          load_val_s = LD_SUGAR;
        end else if (tmr_zero_s) begin
          nxt_s = ST_FINISH;
        end else begin
          nxt_s = ST_CREAM;
        end
      end
      ST_SUGAR: begin
        if (tmr_zero_s) begin
          nxt_s = ST_FINISH;
        end else begin
          nxt_s = ST_SUGAR;
        end
      end
      ST_FINISH: begin
        nxt_s = ST_IDLE;
      end
      default: begin
        nxt_s = ST_IDLE;
      end
    endcase

    // DONE has already gone out in FINISH, so abort there is silent.
    if (ABORT && (state_r != ST_IDLE)) begin
      nxt_s       = ST_IDLE;
      load_s      = 1'b1;
      load_val_s  = {CNT_W{1'b0}};
      abort_hit_s = (state_r != ST_FINISH);
    end else begin
      abort_hit_s = 1'b0;
    end
  end

  // State, latched recipe and outputs registered together from the next state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      rcp_r        <= RCP_NONE;
      STEP         <= STEP_IDLE;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      ABORTED      <= 1'b0;
      VALVE_WATER  <= 1'b0;
      VALVE_COFFEE <= 1'b0;
      VALVE_CREAM  <= 1'b0;
      VALVE_SUGAR  <= 1'b0;
    end else begin
      state_r <= nxt_s;
      if ((state_r == ST_IDLE) && (nxt_s == ST_WATER)) begin
        rcp_r <= RECIPE;
      end else begin
        rcp_r <= rcp_r;
      end
      STEP         <= nxt_s;
      BUSY         <= (nxt_s != ST_IDLE);
      DONE         <= (nxt_s == ST_FINISH);
      ABORTED      <= abort_hit_s;
      VALVE_WATER  <= (nxt_s == ST_WATER);
      VALVE_COFFEE <= (nxt_s == ST_COFFEE);
      VALVE_CREAM  <= (nxt_s == ST_CREAM);
      VALVE_SUGAR  <= (nxt_s == ST_SUGAR);
    end
  end

endmodule

// File: tb/tb_coffee_dispense_sequencer.sv
// Self-checking bench: directed test-plan scenarios with literal expectations,
// then random stimulus checked every cycle against a schedule-based model.
module tb_coffee_dispense_sequencer;

  localparam int TW = 3;
  localparam int TC = 2;
  localparam int TM = 2;
  localparam int TS = 1;

  typedef int iq_t[$];

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [1:0] RECIPE;
  logic       ABORT;
  logic       BUSY, DONE, ABORTED;
  logic       VALVE_WATER, VALVE_COFFEE, VALVE_CREAM, VALVE_SUGAR;
  logic [2:0] STEP;

  int  checks   = 0;
  int  failures = 0;
  int  exp_step = 0;
  bit  exp_ab   = 1'b0;
  iq_t sched_q;

  coffee_dispense_sequencer #(
    .T_WATER (TW), .T_COFFEE (TC), .T_CREAM (TM), .T_SUGAR (TS), .CNT_W (10)
  ) dut (
    .CLK (CLK), .RST (RST), .START (START), .RECIPE (RECIPE), .ABORT (ABORT),
    .BUSY (BUSY), .DONE (DONE), .ABORTED (ABORTED),
    .VALVE_WATER (VALVE_WATER), .VALVE_COFFEE (VALVE_COFFEE),
    .VALVE_CREAM (VALVE_CREAM), .VALVE_SUGAR (VALVE_SUGAR), .STEP (STEP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // The whole cup as a list of per-cycle step codes, finish included.
  function automatic iq_t sched(input logic [1:0] r);
    iq_t s;
    for (int i = 0; i < TW; i++) s.push_back(1);
    for (int i = 0; i < TC; i++) s.push_back(2);
    if (r[1]) for (int i = 0; i < TM; i++) s.push_back(3);
    if (r == 2'b11) for (int i = 0; i < TS; i++) s.push_back(4);
    s.push_back(5);
    return s;
  endfunction

  task automatic model_edge(input bit s, input logic [1:0] r, input bit a, input bit rs);
    exp_ab = 1'b0;
    if (rs) begin
      sched_q.delete();
      exp_step = 0;
    end else if (exp_step == 0) begin
      if (s && r != 2'b00 && !a) begin
        sched_q  = sched(r);
        exp_step = sched_q.pop_front();
      end
    end else if (a) begin
      exp_ab   = (exp_step != 5);
      sched_q.delete();
      exp_step = 0;
    end else begin
      exp_step = (sched_q.size() > 0) ? sched_q.pop_front() : 0;
    end
  endtask

  task automatic compare_all();
    chk("step", STEP, exp_step);
    chk("valve_water", VALVE_WATER, exp_step == 1);
    chk("valve_coffee", VALVE_COFFEE, exp_step == 2);
    chk("valve_cream", VALVE_CREAM, exp_step == 3);
    chk("valve_sugar", VALVE_SUGAR, exp_step == 4);
    chk("busy", BUSY, exp_step != 0);
    chk("done", DONE, exp_step == 5);
    chk("aborted", ABORTED, exp_ab);
  endtask

  task automatic cycle(input bit s, input logic [1:0] r, input bit a, input bit rs);
    START = s; RECIPE = r; ABORT = a; RST = rs;
    @(posedge CLK);
    model_edge(s, r, a, rs);
    @(negedge CLK);
    compare_all();
  endtask

  int seq_cs[10] = '{1, 1, 1, 2, 2, 3, 3, 4, 5, 0};

  initial begin
    START = 1'b0; RECIPE = 2'b00; ABORT = 1'b0; RST = 1'b1;

    chk("model_len_black", sched(2'b01).size(), 6);
    chk("model_len_cream", sched(2'b10).size(), 8);
    chk("model_len_cs", sched(2'b11).size(), 9);

    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    chk("reset_step", STEP, 0);
    chk("reset_busy", BUSY, 0);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Black
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) cycle(1'b0, 2'b00, 1'b0, 1'b0);
      chk("black_water", VALVE_WATER, k >= 1 && k <= 3);
      chk("black_coffee", VALVE_COFFEE, k == 4 || k == 5);
      chk("black_done", DONE, k == 6);
      chk("black_busy", BUSY, k <= 6);
    end

    // Cream + sugar
    cycle(1'b1, 2'b11, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) cycle(1'b0, 2'b00, 1'b0, 1'b0);
      chk("cs_step", STEP, seq_cs[k-1]);
    end

    // Invalid recipe, then START during a cream dispense
    cycle(1'b1, 2'b00, 1'b0, 1'b0);
    chk("invalid_step", STEP, 0);
    chk("invalid_busy", BUSY, 0);
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int k = 2; k <= 9; k++) begin
      cycle(k == 3, 2'b01, 1'b0, 1'b0);
      chk("busy_start_cream", VALVE_CREAM, k == 6 || k == 7);
      chk("busy_start_done", DONE, k == 8);
      chk("busy_start_busy", BUSY, k <= 8);
    end

    // Abort during coffee
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      cycle(1'b0, 2'b00, k == 6, 1'b0);
      chk("abort_pulse", ABORTED, k == 6);
      chk("abort_busy", BUSY, k <= 5);
      chk("abort_done", DONE, 0);
      chk("abort_coffee", VALVE_COFFEE, k == 4 || k == 5);
    end
    cycle(1'b1, 2'b01, 1'b1, 1'b0);
    chk("abort_start_idle_step", STEP, 0);
    chk("abort_start_idle_aborted", ABORTED, 0);

    // Reset mid-cream, then a fresh black cup
    cycle(1'b1, 2'b10, 1'b0, 1'b0);
    for (int k = 2; k <= 5; k++) begin
      cycle(1'b0, 2'b00, 1'b0, k == 5);
    end
    chk("rst_mid_valves", {VALVE_WATER, VALVE_COFFEE, VALVE_CREAM, VALVE_SUGAR}, 0);
    chk("rst_mid_flags", {BUSY, DONE, ABORTED}, 0);
    chk("rst_mid_step", STEP, 0);

    // Back-to-back: START in FINISH dropped, START in next IDLE accepted
    cycle(1'b1, 2'b01, 1'b0, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      cycle(k >= 7, 2'b01, 1'b0, 1'b0);
      chk("b2b_done", DONE, k == 6);
      chk("b2b_busy", BUSY, k <= 6 || k == 8);
      chk("b2b_water", VALVE_WATER, k <= 3 || k == 8);
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 2'b00, 1'b0, 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
            $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
